sr_flag_arbiter: RTL

Arbitrated controller for a bank of SR-style status flags. Up to NREQ requesters issue set/clear commands against individual flags over a valid/ready handshake. A round-robin arbiter grants one command at a time, and a two-state sequencer applies it. The illegal S=R=1 case is resolved deterministically: the flag is held and a sticky error is raised, never an unknown value. The block sits between the control agents and any logic consuming the flag vector q / q_bar.

---
 rtl/sr_flag_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sr_flag_arbiter.sv
// Bank of SR-style status flags driven by NREQ requesters through a round-robin
// arbiter and a two-state IDLE/APPLY sequencer. S=R=1 holds the flag and raises a sticky error.
module sr_flag_arbiter #(
    parameter int NFLAGS = 8,
    parameter int IDXW   = 3,
    parameter int NREQ   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [IDXW*NREQ-1:0] req_idx,
    output logic [NREQ-1:0]      req_ready,
    output logic [NFLAGS-1:0]    q,
    output logic [NFLAGS-1:0]    q_bar,
    output logic                 done,
    output logic [2:0]           done_id,
    output logic                 err,
    input  logic                 err_clr,
    output logic [15:0]          cmd_count
);

    typedef enum logic {IDLE, APPLY} state_t;

    state_t            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [1:0]        cmdOp_q, cmdOp_d;
    logic [IDXW-1:0]   cmdIdx_q, cmdIdx_d;
    logic [2:0]        cmdId_q, cmdId_d;
    logic [NFLAGS-1:0] flags_q, flags_d;
    logic              done_q, done_d;
    logic [2:0]        doneId_q, doneId_d;
    logic              err_q, err_d;
    logic [15:0]       cmdCount_q, cmdCount_d;

    logic              found;
    logic [2:0]        winner;
    logic              badIdx;
    logic              newErr;

    // First valid requester at or after the pointer, searching upward with wrap.
    always_comb begin
        int cand;
        found  = 1'b0;
        winner = 3'd0;
        cand   = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr_q) + k) % NREQ;
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = 3'(cand);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            req_ready[k] = (state_q == IDLE) && found && (int'(winner) == k);
        end
    end

    assign badIdx = (int'(cmdIdx_q) >= NFLAGS);
    assign newErr = (state_q == APPLY) && (badIdx || (cmdOp_q == 2'b11));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cmdOp_d    = cmdOp_q;
        cmdIdx_d   = cmdIdx_q;
        cmdId_d    = cmdId_q;
        flags_d    = flags_q;
        done_d     = 1'b0;
        doneId_d   = doneId_q;
        cmdCount_d = cmdCount_q;
        err_d      = err_q;

        // A new error at the same edge as err_clr must win.
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (newErr) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    cmdOp_d  = req_op[2*int'(winner) +: 2];
                    cmdIdx_d = req_idx[IDXW*int'(winner) +: IDXW];
                    cmdId_d  = winner;
                    ptr_d    = 3'((int'(winner) + 1) % NREQ);
                    state_d  = APPLY;
                end
            end
            APPLY: begin
                if (!badIdx) begin
                    case (cmdOp_q)
                        2'b01:   flags_d[cmdIdx_q] = 1'b0;
                        2'b10:   flags_d[cmdIdx_q] = 1'b1;
                        default: flags_d = flags_q;
                    endcase
                end
                done_d     = 1'b1;
                doneId_d   = cmdId_q;
                cmdCount_d = cmdCount_q + 16'd1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= 3'd0;
            cmdOp_q    <= 2'b00;
            cmdIdx_q   <= '0;
            cmdId_q    <= 3'd0;
            flags_q    <= '0;
            done_q     <= 1'b0;
            doneId_q   <= 3'd0;
            err_q      <= 1'b0;
            cmdCount_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cmdOp_q    <= cmdOp_d;
            cmdIdx_q   <= cmdIdx_d;
            cmdId_q    <= cmdId_d;
            flags_q    <= flags_d;
            done_q     <= done_d;
            doneId_q   <= doneId_d;
            err_q      <= err_d;
            cmdCount_q <= cmdCount_d;
        end
    end

    assign q         = flags_q;
    assign q_bar     = ~flags_q;
    assign done      = done_q;
    assign done_id   = doneId_q;
    assign err       = err_q;
    assign cmd_count = cmdCount_q;

endmodule
